// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared frame geometry, pixel format and store state encoding
package img_pkg;

    localparam int IMG_DIM = 64;
    localparam int PIX_W   = 24;
    localparam int AW      = $clog2(IMG_DIM);
    localparam int NPIX    = IMG_DIM * IMG_DIM;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        PROC = 2'd1,
        DUMP = 2'd2
    } state_t;

    // Colour field slices of a packed pixel
    function automatic logic [7:0] pix_r(input logic [PIX_W-1:0] p);
        return p[23:16];
    endfunction

    function automatic logic [7:0] pix_g(input logic [PIX_W-1:0] p);
        return p[15:8];
    endfunction

    function automatic logic [7:0] pix_b(input logic [PIX_W-1:0] p);
        return p[7:0];
    endfunction

endpackage

// File: rtl/img_raster_cnt.sv
// rtl/img_raster_cnt.sv - raster-order row/col counter, col advances first
module img_raster_cnt
    import img_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr,
    output logic [AW-1:0] row,
    output logic [AW-1:0] col,
    output logic          last
);

    localparam logic [AW-1:0] MAX = AW'(IMG_DIM - 1);

    logic [AW-1:0] row_q, row_d;
    logic [AW-1:0] col_q, col_d;

    // Next position: clear wins, otherwise step col and carry into row; wraps to 0 after the last pixel
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (en) begin
            if (col_q == MAX) begin
                col_d = '0;
                row_d = (row_q == MAX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Position register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = (row_q == MAX) && (col_q == MAX);

endmodule

// File: rtl/image_store.sv
// rtl/image_store.sv - frame memory: host load, engine read/write, streamed dump (optional IMAGE_STORE_WRCNT_EN adds wr_cnt)
module image_store
    import img_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [PIX_W-1:0] ld_pix,
    output logic             frame_rdy,
    input  logic [AW-1:0]    row,
    input  logic [AW-1:0]    col,
    output logic [PIX_W-1:0] in_pix,
    input  logic             out_we,
    input  logic [PIX_W-1:0] out_pix,
    input  logic             proc_done,
    output logic             dp_valid,
    input  logic             dp_ready,
    output logic [PIX_W-1:0] dp_pix,
    output logic             dp_last
`ifdef IMAGE_STORE_WRCNT_EN
    ,
    output logic [2*AW:0]    wr_cnt
`endif
);

    state_t state_q;
    logic   ld_ready_q;
    logic   frame_rdy_q;
    logic   dp_valid_q;

    logic [AW-1:0] ld_row, ld_col, dp_row, dp_col;
    logic          ld_last, dp_last_pos;

    logic [PIX_W-1:0] mem [NPIX];

    logic ld_fire;
    logic dp_fire;
    logic eng_we;

    assign ld_fire = ld_ready_q && ld_valid;
    assign dp_fire = dp_valid_q && dp_ready;
    assign eng_we  = frame_rdy_q && out_we;

    img_raster_cnt u_ld_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ld_fire),
        .clr   (!ld_ready_q),
        .row   (ld_row),
        .col   (ld_col),
        .last  (ld_last)
    );

    img_raster_cnt u_dp_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (dp_fire),
        .clr   (!dp_valid_q),
        .row   (dp_row),
        .col   (dp_col),
        .last  (dp_last_pos)
    );

    // Phase sequencer with the handshake flags registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            ld_ready_q  <= 1'b1;
            frame_rdy_q <= 1'b0;
            dp_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (ld_fire && ld_last) begin
                        state_q     <= PROC;
                        ld_ready_q  <= 1'b0;
                        frame_rdy_q <= 1'b1;
                    end
                end
                PROC: begin
                    if (proc_done) begin
                        state_q     <= DUMP;
                        frame_rdy_q <= 1'b0;
                        dp_valid_q  <= 1'b1;
                    end
                end
                DUMP: begin
                    if (dp_fire && dp_last_pos) begin
                        state_q    <= LOAD;
                        dp_valid_q <= 1'b0;
                        ld_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= LOAD;
                    ld_ready_q  <= 1'b1;
                    frame_rdy_q <= 1'b0;
                    dp_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    // Single write port: host load during LOAD, engine write during PROC; contents survive reset
    always_ff @(posedge clk) begin
        if (ld_fire) begin
            mem[{ld_row, ld_col}] <= ld_pix;
        end else if (eng_we) begin
            mem[{row, col}] <= out_pix;
        end
    end

    assign in_pix    = mem[{row, col}];
    assign dp_pix    = mem[{dp_row, dp_col}];
    assign dp_last   = dp_valid_q && dp_last_pos;
    assign ld_ready  = ld_ready_q;
    assign frame_rdy = frame_rdy_q;
    assign dp_valid  = dp_valid_q;

`ifdef IMAGE_STORE_WRCNT_EN
    logic [2*AW:0] wr_cnt_q;

    // Committed engine writes in the current PROC phase, cleared as PROC is entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q <= '0;
        end else if (ld_fire && ld_last) begin
            wr_cnt_q <= '0;
        end else if (eng_we && (wr_cnt_q != '1)) begin
            wr_cnt_q <= wr_cnt_q + 1'b1;
        end
    end

    assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_image_store.sv
// tb/tb_image_store.sv - scoreboard bench for image_store
module tb_image_store;
    import img_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ld_valid;
    logic             ld_ready;
    logic [PIX_W-1:0] ld_pix;
    logic             frame_rdy;
    logic [AW-1:0]    row;
    logic [AW-1:0]    col;
    logic [PIX_W-1:0] in_pix;
    logic             out_we;
    logic [PIX_W-1:0] out_pix;
    logic             proc_done;
    logic             dp_valid;
    logic             dp_ready;
    logic [PIX_W-1:0] dp_pix;
    logic             dp_last;
`ifdef IMAGE_STORE_WRCNT_EN
    logic [2*AW:0]    wr_cnt;
`endif

    int vecs = 0;
    int errs = 0;

    logic [PIX_W-1:0] model [NPIX];
    logic [PIX_W-1:0] exp_q [$];

    always #5 clk = ~clk;

    image_store dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_pix    (ld_pix),
        .frame_rdy (frame_rdy),
        .row       (row),
        .col       (col),
        .in_pix    (in_pix),
        .out_we    (out_we),
        .out_pix   (out_pix),
        .proc_done (proc_done),
        .dp_valid  (dp_valid),
        .dp_ready  (dp_ready),
        .dp_pix    (dp_pix),
        .dp_last   (dp_last)
`ifdef IMAGE_STORE_WRCNT_EN
        ,
        .wr_cnt    (wr_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        ld_valid  = 1'b0;
        ld_pix    = '0;
        row       = '0;
        col       = '0;
        out_we    = 1'b0;
        out_pix   = '0;
        proc_done = 1'b0;
        dp_ready  = 1'b0;
        #22;
        vecs++;
        if (frame_rdy !== 1'b0 || dp_valid !== 1'b0 || dp_last !== 1'b0) begin
            errs++;
            $display("FAIL reset_flags: frame_rdy=%b dp_valid=%b dp_last=%b, need 0/0/0", frame_rdy, dp_valid, dp_last);
        end
        tick();
        rst_n = 1'b1;
        #1;
        vecs++;
        if (ld_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_ld_ready: got %b need 1", ld_ready);
        end
`ifdef IMAGE_STORE_WRCNT_EN
        vecs++;
        if (wr_cnt !== '0) begin
            errs++;
            $display("FAIL reset_wr_cnt: got %0d need 0", wr_cnt);
        end
`endif
    endtask

    // Load a full frame; with gaps=1 ld_valid drops randomly. Checks PROC entry timing.
    task automatic load_frame(input logic [PIX_W-1:0] xor_mask, input bit gaps);
        int accepts = 0;
        int cyc = 0;
        while (accepts < NPIX && cyc < 40000) begin
            ld_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            ld_pix   = PIX_W'(accepts) ^ xor_mask;
            #1;
            if (accepts == NPIX - 1 && ld_valid) begin
                vecs++;
                if (ld_ready !== 1'b1 || frame_rdy !== 1'b0) begin
                    errs++;
                    $display("FAIL load_last_pending: ld_ready=%b frame_rdy=%b need 1/0", ld_ready, frame_rdy);
                end
            end
            if (ld_valid && ld_ready) begin
                model[accepts] = ld_pix;
                accepts++;
            end
            tick();
            cyc++;
        end
        ld_valid = 1'b0;
        vecs++;
        if (accepts != NPIX || frame_rdy !== 1'b1 || ld_ready !== 1'b0) begin
            errs++;
            $display("FAIL load_to_proc: accepts=%0d frame_rdy=%b ld_ready=%b need %0d/1/0", accepts, frame_rdy, ld_ready, NPIX);
        end
        tick();
        vecs++;
        if (ld_ready !== 1'b0) begin
            errs++;
            $display("FAIL ld_ready_after_load: got %b need 0", ld_ready);
        end
    endtask

    task automatic read_check(input int r, input int c, input string nm);
        logic [PIX_W-1:0] exp;
        row = AW'(r);
        col = AW'(c);
        exp_q.push_back(model[r*IMG_DIM + c]);
        #1;
        exp = exp_q.pop_front();
        vecs++;
        if (in_pix !== exp) begin
            errs++;
            $display("FAIL %s: in_pix[%0d][%0d]=%h need %h", nm, r, c, in_pix, exp);
        end
    endtask

    task automatic eng_write(input int r, input int c, input logic [PIX_W-1:0] d);
        row     = AW'(r);
        col     = AW'(c);
        out_we  = 1'b1;
        out_pix = d;
        model[r*IMG_DIM + c] = d;
        tick();
        out_we  = 1'b0;
    endtask

    task automatic test_proc_read();
        read_check(5, 7, "proc_read_5_7");
        vecs++;
        if (in_pix !== 24'h000147) begin
            errs++;
            $display("FAIL proc_read_const: got %h need 000147", in_pix);
        end
        for (int k = 0; k < 6; k++)
            read_check($urandom_range(0, 63), $urandom_range(0, 63), "proc_read_rand");
    endtask

    task automatic test_proc_write();
        eng_write(5, 7, 24'h00AB00);
        read_check(5, 7, "proc_write_readback");
        vecs++;
        if (in_pix !== 24'h00AB00) begin
            errs++;
            $display("FAIL proc_write_const: got %h need 00AB00", in_pix);
        end
        for (int k = 0; k < 8; k++) begin
            eng_write(10 + k, 3 * k, PIX_W'(32'hC0DE00 + k));
            read_check(10 + k, 3 * k, "proc_write_rand");
        end
    endtask

    task automatic test_proc_done_write();
        row       = 6'd63;
        col       = 6'd63;
        out_we    = 1'b1;
        out_pix   = 24'hFFFFFF;
        proc_done = 1'b1;
        model[NPIX-1] = 24'hFFFFFF;
        tick();
        out_we    = 1'b0;
        proc_done = 1'b0;
        vecs++;
        if (dp_valid !== 1'b1 || frame_rdy !== 1'b0) begin
            errs++;
            $display("FAIL proc_to_dump: dp_valid=%b frame_rdy=%b need 1/0", dp_valid, frame_rdy);
        end
`ifdef IMAGE_STORE_WRCNT_EN
        vecs++;
        if (wr_cnt !== 13'd10) begin
            errs++;
            $display("FAIL wr_cnt_10: got %0d need 10", wr_cnt);
        end
`endif
    endtask

    // Dump with dp_ready toggling; engine writes held on throughout must be ignored
    task automatic test_dump();
        logic [PIX_W-1:0] held;
        logic             stalled = 1'b0;
        int               cyc = 0;
        for (int i = 0; i < NPIX; i++) exp_q.push_back(model[i]);
        row     = 6'd63;
        col     = 6'd62;
        out_we  = 1'b1;
        out_pix = 24'h123456;
        dp_ready = 1'b1;
        while (exp_q.size() > 0 && cyc < 20000) begin
            #1;
            vecs++;
            if (dp_valid !== 1'b1 || dp_pix !== exp_q[0] || dp_last !== (exp_q.size() == 1)) begin
                errs++;
                $display("FAIL dump_pix: idx=%0d valid=%b pix=%h last=%b need 1/%h/%b", NPIX - exp_q.size(), dp_valid, dp_pix, dp_last, exp_q[0], exp_q.size() == 1);
            end
            if (stalled) begin
                vecs++;
                if (dp_pix !== held) begin
                    errs++;
                    $display("FAIL dump_stall_stable: pix=%h need %h", dp_pix, held);
                end
            end
            held    = dp_pix;
            stalled = !dp_ready;
            if (dp_ready) void'(exp_q.pop_front());
            tick();
            dp_ready = ~dp_ready;
            cyc++;
        end
        out_we   = 1'b0;
        dp_ready = 1'b0;
        #1;
        vecs++;
        if (exp_q.size() != 0 || ld_ready !== 1'b1 || dp_valid !== 1'b0) begin
            errs++;
            $display("FAIL dump_to_load: left=%0d ld_ready=%b dp_valid=%b need 0/1/0", exp_q.size(), ld_ready, dp_valid);
        end
        exp_q.delete();
`ifdef IMAGE_STORE_WRCNT_EN
        vecs++;
        if (wr_cnt !== 13'd10) begin
            errs++;
            $display("FAIL wr_cnt_hold: got %0d need 10", wr_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid_load();
        for (int i = 0; i < 100; i++) begin
            ld_valid = 1'b1;
            ld_pix   = 24'h777000;
            tick();
        end
        ld_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #2;
        vecs++;
        if (ld_ready !== 1'b1 || frame_rdy !== 1'b0) begin
            errs++;
            $display("FAIL mid_load_reset: ld_ready=%b frame_rdy=%b need 1/0", ld_ready, frame_rdy);
        end
        tick();
        rst_n = 1'b1;
        load_frame(24'h5A0000, 1'b1);
        read_check(0, 0, "reload_first");
        read_check(1, 36, "reload_mid");
        read_check(63, 63, "reload_last");
`ifdef IMAGE_STORE_WRCNT_EN
        vecs++;
        if (wr_cnt !== '0) begin
            errs++;
            $display("FAIL wr_cnt_clear: got %0d need 0", wr_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        load_frame('0, 1'b0);
        test_proc_read();
        test_proc_write();
        test_proc_done_write();
        test_dump();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
